// File: rtl/core_alu_pkg.sv
// Shared definitions for the core ALU arbiter: opcode numbering in ALU_SEL
// bit order and the arbiter FSM encoding.
package core_alu_pkg;

  localparam int NUM_ALU_OPS = 34;

  localparam int ADDI = 0;
  localparam int SLTI = 1;
  localparam int SLTIU = 2;
  localparam int XORI = 3;
  localparam int ORI = 4;
  localparam int ANDI = 5;
  localparam int SLLI = 6;
  localparam int SRLI = 7;
  localparam int SRAI = 8;
  localparam int ADD = 9;
  localparam int SUB = 10;
  localparam int SLL = 11;
  localparam int SLT = 12;
  localparam int SLTU = 13;
  localparam int XOR = 14;
  localparam int SRL = 15;
  localparam int SRA = 16;
  localparam int OR = 17;
  localparam int AND = 18;
  localparam int BEQ = 19;
  localparam int BNE = 20;
  localparam int BLT = 21;
  localparam int BGE = 22;
  localparam int BLTU = 23;
  localparam int BGEU = 24;
  localparam int LB = 25;
  localparam int LH = 26;
  localparam int LW = 27;
  localparam int LBU = 28;
  localparam int LHU = 29;
  localparam int SB = 30;
  localparam int SH = 31;
  localparam int SW = 32;
  localparam int ROT = 33;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/core_alu_opdec.sv
// Compact opcode to one-hot ALU strobe decoder; opcodes past the last ALU op
// decode to all-zero so the ALU idles.
module core_alu_opdec
  import core_alu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0]         op_i,
  output logic [NUM_ALU_OPS-1:0] sel_o
);

  for (genvar i = 0; i < NUM_ALU_OPS; i++) begin : g_bit
    assign sel_o[i] = (op_i == OPW'(i));
  end

endmodule

// File: rtl/core_alu_arb.sv
// Round-robin sharing of the registered core ALU between the execute pipe (R0)
// and the address-gen/debug port (R1); one op in flight, result returned via valid/ready.
module core_alu_arb
  import core_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   R0_REQ,
  output logic                   R0_GNT,
  input  logic [OPW-1:0]         R0_OP,
  input  logic [XLEN-1:0]        R0_RS1,
  input  logic [XLEN-1:0]        R0_RS2,
  input  logic [XLEN-1:0]        R0_IMM,
  input  logic                   R1_REQ,
  output logic                   R1_GNT,
  input  logic [OPW-1:0]         R1_OP,
  input  logic [XLEN-1:0]        R1_RS1,
  input  logic [XLEN-1:0]        R1_RS2,
  input  logic [XLEN-1:0]        R1_IMM,
  output logic                   R0_RSP_VALID,
  input  logic                   R0_RSP_READY,
  output logic                   R1_RSP_VALID,
  input  logic                   R1_RSP_READY,
  output logic [XLEN-1:0]        RSP_DATA,
  input  logic                   FLUSH,
  output logic                   BUSY,
  output logic [NUM_ALU_OPS-1:0] ALU_SEL,
  output logic [XLEN-1:0]        ALU_RS1,
  output logic [XLEN-1:0]        ALU_RS2,
  output logic [XLEN-1:0]        ALU_IMM,
  input  logic [XLEN-1:0]        ALU_RESULT
);

  logic [1:0]             state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   own_q, own_d;
  logic [NUM_ALU_OPS-1:0] sel_q, sel_d, dec_sel;
  logic [XLEN-1:0]        rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   idle, g0, g1, own_rdy;
  logic [OPW-1:0]         win_op;

  // Grants are gated by reset so nothing is offered while the block is held in reset.
  assign idle = (state_q == ST_IDLE);
  assign g0   = RST_N & idle & ~FLUSH & R0_REQ & (~R1_REQ | ~ptr_q);
  assign g1   = RST_N & idle & ~FLUSH & R1_REQ & (~R0_REQ |  ptr_q);

  assign win_op  = g1 ? R1_OP : R0_OP;
  assign own_rdy = own_q ? R1_RSP_READY : R0_RSP_READY;

  core_alu_opdec #(.OPW(OPW)) u_dec (
    .op_i  (win_op),
    .sel_o (dec_sel)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    sel_d   = sel_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (g0 | g1) begin
          own_d   = g1;
          ptr_d   = ~g1;
          sel_d   = dec_sel;
          rs1_d   = g1 ? R1_RS1 : R0_RS1;
          rs2_d   = g1 ? R1_RS2 : R0_RS2;
          imm_d   = g1 ? R1_IMM : R0_IMM;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Strobe lasts exactly one cycle: the ALU samples it at the end of EXEC.
        sel_d   = '0;
        state_d = FLUSH ? ST_IDLE : ST_CAPT;
      end
      ST_CAPT: begin
        sel_d = '0;
        if (FLUSH) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = ALU_RESULT;
          state_d = ST_RESP;
        end
      end
      default: begin
        sel_d = '0;
        if (FLUSH || own_rdy) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      sel_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      sel_q   <= sel_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      data_q  <= data_d;
    end
  end

  assign R0_GNT       = g0;
  assign R1_GNT       = g1;
  assign R0_RSP_VALID = (state_q == ST_RESP) & ~own_q;
  assign R1_RSP_VALID = (state_q == ST_RESP) &  own_q;
  assign RSP_DATA     = data_q;
  assign BUSY         = ~idle;
  assign ALU_SEL      = sel_q;
  assign ALU_RS1      = rs1_q;
  assign ALU_RS2      = rs2_q;
  assign ALU_IMM      = imm_q;

endmodule

// File: tb/tb_core_alu_arb.sv
// Directed bench for core_alu_arb with a small registered ALU model attached.
module tb_core_alu_arb;
  import core_alu_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 6;

  logic                   CLK = 1'b0;
  logic                   RST_N;
  logic                   R0_REQ, R0_GNT, R1_REQ, R1_GNT;
  logic [OPW-1:0]         R0_OP, R1_OP;
  logic [XLEN-1:0]        R0_RS1, R0_RS2, R0_IMM, R1_RS1, R1_RS2, R1_IMM;
  logic                   R0_RSP_VALID, R0_RSP_READY, R1_RSP_VALID, R1_RSP_READY;
  logic [XLEN-1:0]        RSP_DATA;
  logic                   FLUSH, BUSY;
  logic [NUM_ALU_OPS-1:0] ALU_SEL;
  logic [XLEN-1:0]        ALU_RS1, ALU_RS2, ALU_IMM, ALU_RESULT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  core_alu_arb #(.XLEN(XLEN), .OPW(OPW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .R0_REQ(R0_REQ), .R0_GNT(R0_GNT), .R0_OP(R0_OP),
    .R0_RS1(R0_RS1), .R0_RS2(R0_RS2), .R0_IMM(R0_IMM),
    .R1_REQ(R1_REQ), .R1_GNT(R1_GNT), .R1_OP(R1_OP),
    .R1_RS1(R1_RS1), .R1_RS2(R1_RS2), .R1_IMM(R1_IMM),
    .R0_RSP_VALID(R0_RSP_VALID), .R0_RSP_READY(R0_RSP_READY),
    .R1_RSP_VALID(R1_RSP_VALID), .R1_RSP_READY(R1_RSP_READY),
    .RSP_DATA(RSP_DATA), .FLUSH(FLUSH), .BUSY(BUSY),
    .ALU_SEL(ALU_SEL), .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2),
    .ALU_IMM(ALU_IMM), .ALU_RESULT(ALU_RESULT)
  );

  // Attached ALU: one-cycle registered result; ROT is a byte reversal here.
  function automatic logic [31:0] alu_f(input logic [NUM_ALU_OPS-1:0] s,
                                        input logic [31:0] a, b, i);
    if (s[ADD])  return a + b;
    if (s[SUB])  return a - b;
    if (s[SLTI]) return {31'd0, $signed(a) < $signed(i)};
    if (s[ROT])  return {a[7:0], a[15:8], a[23:16], a[31:24]};
    return '0;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ALU_RESULT <= '0;
    else        ALU_RESULT <= alu_f(ALU_SEL, ALU_RS1, ALU_RS2, ALU_IMM);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_ALU_OPS-1:0] one;
    one = 1;
    RST_N = 1'b0; FLUSH = 1'b0;
    R0_REQ = 1'b1; R0_OP = '0; R0_RS1 = '0; R0_RS2 = '0; R0_IMM = '0;
    R1_REQ = 1'b0; R1_OP = '0; R1_RS1 = '0; R1_RS2 = '0; R1_IMM = '0;
    R0_RSP_READY = 1'b0; R1_RSP_READY = 1'b0;
    #3;
    chk("rst_gnt0", R0_GNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_sel", ALU_SEL, 0);
    chk("rst_data", RSP_DATA, 0);
    chk("rst_vld0", R0_RSP_VALID, 0);
    R0_REQ = 1'b0;
    nc; RST_N = 1'b1;

    // Single R0 ADD: grant c0, strobe c1, response c3, idle c4
    nc; R0_REQ = 1; R0_OP = OPW'(ADD); R0_RS1 = 5; R0_RS2 = 7; R0_RSP_READY = 1; #1;
    chk("add_gnt0", R0_GNT, 1);
    chk("add_gnt1", R1_GNT, 0);
    chk("add_busy0", BUSY, 0);
    nc; R0_REQ = 0; #1;
    chk("add_sel", ALU_SEL, one << ADD);
    chk("add_rs1", ALU_RS1, 5);
    chk("add_rs2", ALU_RS2, 7);
    chk("add_busy1", BUSY, 1);
    nc; #1;
    chk("add_sel_capt", ALU_SEL, 0);
    chk("add_vld_capt", R0_RSP_VALID, 0);
    nc; #1;
    chk("add_vld", R0_RSP_VALID, 1);
    chk("add_data", RSP_DATA, 12);
    chk("add_vld1", R1_RSP_VALID, 0);
    nc; #1;
    chk("add_idle", BUSY, 0);
    chk("add_vld_drop", R0_RSP_VALID, 0);

    // R1 SLTI with response backpressure; R0 waits with a pending SUB
    R1_REQ = 1; R1_OP = OPW'(SLTI); R1_RS1 = 32'hFFFF_FFFF; R1_IMM = 1; R1_RSP_READY = 0; #1;
    chk("slti_gnt1", R1_GNT, 1);
    nc; R1_REQ = 0; R0_REQ = 1; R0_OP = OPW'(SUB); R0_RS1 = 10; R0_RS2 = 3; #1;
    chk("slti_no_gnt_exec", R0_GNT, 0);
    nc;
    for (int k = 0; k < 5; k++) begin
      nc; #1;
      chk("slti_vld_hold", R1_RSP_VALID, 1);
      chk("slti_data_hold", RSP_DATA, 1);
      chk("slti_no_gnt", R0_GNT, 0);
    end
    nc; R1_RSP_READY = 1; #1;
    chk("slti_vld_last", R1_RSP_VALID, 1);

    // Both requesters held: pointer alternates R0, R1, R0
    nc; R1_REQ = 1; R1_OP = OPW'(ROT); R1_RS1 = 32'h1122_3344; #1;
    chk("rr_gnt0_a", R0_GNT, 1);
    chk("rr_gnt1_a", R1_GNT, 0);
    nc; #1;
    chk("sub_sel", ALU_SEL, one << SUB);
    nc; nc; #1;
    chk("sub_vld0", R0_RSP_VALID, 1);
    chk("sub_data", RSP_DATA, 7);
    chk("sub_vld1", R1_RSP_VALID, 0);
    nc; #1;
    chk("rr_gnt1_b", R1_GNT, 1);
    chk("rr_gnt0_b", R0_GNT, 0);
    nc; nc; nc; #1;
    chk("rot_vld1", R1_RSP_VALID, 1);
    chk("rot_data", RSP_DATA, 32'h4433_2211);
    chk("rot_vld0", R0_RSP_VALID, 0);
    nc; #1;
    chk("rr_gnt0_c", R0_GNT, 1);

    // FLUSH during CAPT: no response, idle next cycle, new grant there
    nc; R0_REQ = 0; R1_REQ = 0;
    nc; FLUSH = 1; #1;
    chk("fl_capt_busy", BUSY, 1);
    nc; FLUSH = 0; R0_REQ = 1; R0_OP = OPW'(ADD); R0_RS1 = 1; R0_RS2 = 2; #1;
    chk("fl_capt_idle", BUSY, 0);
    chk("fl_capt_novld", R0_RSP_VALID, 0);
    chk("fl_capt_regnt", R0_GNT, 1);
    nc; R0_REQ = 0; R0_RSP_READY = 0;
    nc;
    nc; FLUSH = 1; #1;
    chk("fl_resp_vld", R0_RSP_VALID, 1);
    chk("fl_resp_data", RSP_DATA, 3);

    // FLUSH in RESP drops the response; FLUSH in IDLE blocks the grant
    nc; R0_REQ = 1; R0_OP = OPW'(40); R0_RS1 = 9; R0_RSP_READY = 1; #1;
    chk("fl_resp_novld", R0_RSP_VALID, 0);
    chk("fl_resp_idle", BUSY, 0);
    chk("fl_idle_block", R0_GNT, 0);
    nc; FLUSH = 0; #1;
    chk("oor_gnt", R0_GNT, 1);
    nc; R0_REQ = 0; #1;
    chk("oor_sel_exec", ALU_SEL, 0);
    chk("oor_busy", BUSY, 1);
    nc; #1;
    chk("oor_sel_capt", ALU_SEL, 0);
    nc; #1;
    chk("oor_vld", R0_RSP_VALID, 1);
    chk("oor_data", RSP_DATA, 0);
    chk("oor_sel_resp", ALU_SEL, 0);

    // Async reset mid-EXEC, then pointer back at R0
    nc; R0_REQ = 1; R0_OP = OPW'(ADD); R0_RS1 = 5; R0_RS2 = 7;
    R1_REQ = 1; R1_OP = OPW'(SUB); #1;
    chk("pre_rst_gnt1", R1_GNT, 1);
    chk("pre_rst_gnt0", R0_GNT, 0);
    nc; #1;
    chk("pre_rst_sel", ALU_SEL, one << SUB);
    chk("pre_rst_busy", BUSY, 1);
    #1 RST_N = 0; #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_sel", ALU_SEL, 0);
    chk("arst_rs1", ALU_RS1, 0);
    chk("arst_gnt0", R0_GNT, 0);
    chk("arst_gnt1", R1_GNT, 0);
    nc; RST_N = 1; #1;
    chk("post_rst_gnt0", R0_GNT, 1);
    chk("post_rst_gnt1", R1_GNT, 0);
    nc; R0_REQ = 0; R1_REQ = 0;
    nc; nc; nc; nc;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
